// File: rtl/video_pixel_feeder.sv
// -----------------------------------------------------------------------------
// video_pixel_feeder
//   Buffers a valid/ready pixel stream in a small FIFO and releases one pixel
//   per active display cycle, aligned to the raster by the start-of-frame mark.
//   hsync/vsync/vde and the pixel leave together, one clock after the timing
//   inputs. Underflow and frame misalignment are latched as sticky flags and
//   the feeder resynchronises on the next frame.
//
// Ports
//   clk, reset            pixel clock, synchronous active-high reset
//   hsync_in, vsync_in    active-low syncs from the timing generator
//   vde_in, x_in, y_in    active-area flag and raster coordinates
//   s_valid, s_data,      pixel stream input; s_sof marks a frame's first pixel
//   s_sof, s_ready
//   clear_err             clears the sticky error flags
//   hsync_out, vsync_out, timing re-timed by one clock
//   vde_out
//   rgb_out               pixel aligned with vde_out, zero outside active area
//   locked                feeder is locked to the raster
//   underflow, misalign   sticky error flags
// -----------------------------------------------------------------------------
module video_pixel_feeder #(
  parameter int                DATA_W    = 24,
  parameter int                DEPTH     = 16,
  parameter logic [DATA_W-1:0] BLANK_RGB = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              vde_in,
  input  logic [9:0]        x_in,
  input  logic [9:0]        y_in,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  output logic              s_ready,
  input  logic              clear_err,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              vde_out,
  output logic [DATA_W-1:0] rgb_out,
  output logic              locked,
  output logic              underflow,
  output logic              misalign
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_SEEK   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [DATA_W:0]   mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic [AW:0]       count_next_s;
  logic [1:0]        state_r;
  logic [1:0]        state_s;

  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              start_s;
  logic              head_sof_s;
  logic [DATA_W-1:0] head_data_s;
  logic [DATA_W-1:0] rgb_s;
  logic              uf_set_s;
  logic              mis_set_s;

  assign full_s      = (count_r == (AW+1)'(DEPTH));
  assign empty_s     = (count_r == {(AW+1){1'b0}});
  assign push_s      = s_valid && !full_s;
  assign start_s     = vde_in && (x_in == 10'd0) && (y_in == 10'd0);
  assign head_sof_s  = mem_r[rd_ptr_r][DATA_W];
  assign head_data_s = mem_r[rd_ptr_r][DATA_W-1:0];

  // Occupancy after this cycle's push/pop; pop is only ever raised when non-empty.
  always_comb begin
    count_next_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
  end

  // Alignment state machine: decides pop, next state, pixel colour and error events.
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    uf_set_s  = 1'b0;
    mis_set_s = 1'b0;
    if (vde_in) begin
      rgb_s = BLANK_RGB;
    end else begin
      rgb_s = {DATA_W{1'b0}};
    end
    case (state_r)
      ST_SEEK: begin
        // Throw away pixels until a frame start reaches the head.
        if (!empty_s) begin
          if (head_sof_s) begin
            state_s = ST_WAIT;
          end else begin
            pop_s = 1'b1;
          end
        end else begin
          state_s = ST_SEEK;
        end
      end
      ST_WAIT: begin
        if (start_s && !empty_s && head_sof_s) begin
          pop_s   = 1'b1;
          rgb_s   = head_data_s;
          state_s = ST_LOCKED;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_LOCKED: begin
        if (vde_in) begin
          if (empty_s) begin
            uf_set_s = 1'b1;
            state_s  = ST_SEEK;
          end else if (head_sof_s && !start_s) begin
            // Next frame arrived early: keep its SOF for the next raster start.
            mis_set_s = 1'b1;
            state_s   = ST_WAIT;
          end else if (start_s && !head_sof_s) begin
            // Current frame ran long: its leftovers must be discarded.
            mis_set_s = 1'b1;
            state_s   = ST_SEEK;
          end else begin
            pop_s = 1'b1;
            rgb_s = head_data_s;
          end
        end else begin
          rgb_s = {DATA_W{1'b0}};
        end
      end
      default: begin
        state_s = ST_SEEK;
      end
    endcase
  end

  // FIFO storage; stale entries are harmless because the pointers are flushed on reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {s_sof, s_data};
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      s_ready  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_next_s;
      s_ready <= (count_next_s != (AW+1)'(DEPTH));
    end
  end

  // State register, re-timed video outputs and sticky flags (set wins over clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_SEEK;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      vde_out   <= 1'b0;
      rgb_out   <= {DATA_W{1'b0}};
      locked    <= 1'b0;
      underflow <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      state_r   <= state_s;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      vde_out   <= vde_in;
      rgb_out   <= rgb_s;
      locked    <= (state_s == ST_LOCKED);
      underflow <= uf_set_s  | (underflow & ~clear_err);
      misalign  <= mis_set_s | (misalign  & ~clear_err);
    end
  end

endmodule

// File: tb/tb_video_pixel_feeder.sv
// -----------------------------------------------------------------------------
// tb_video_pixel_feeder
//   Drives a reduced raster (40x12 total, 32x8 active) so that many frames fit
//   in a short run, feeds frames of tagged pixels ({frame id, index}) and checks
//   every output on every cycle against a queue-based model of the feeder's
//   rules, plus literal expectations at hand-picked points.
// -----------------------------------------------------------------------------
module tb_video_pixel_feeder;

  localparam int H_ACT = 32;
  localparam int H_TOT = 40;
  localparam int V_ACT = 8;
  localparam int V_TOT = 12;
  localparam int DEPTH = 16;
  localparam logic [23:0] BLANK = 24'h000000;

  localparam int M_SEEK   = 0;
  localparam int M_WAIT   = 1;
  localparam int M_LOCKED = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        vde_in = 1'b0;
  logic [9:0]  x_in = 10'd0;
  logic [9:0]  y_in = 10'd0;
  logic        s_valid = 1'b0;
  logic [23:0] s_data = 24'h0;
  logic        s_sof = 1'b0;
  logic        s_ready;
  logic        clear_err = 1'b0;
  logic        hsync_out;
  logic        vsync_out;
  logic        vde_out;
  logic [23:0] rgb_out;
  logic        locked;
  logic        underflow;
  logic        misalign;

  video_pixel_feeder #(.DATA_W(24), .DEPTH(DEPTH), .BLANK_RGB(BLANK)) dut (
    .clk(clk), .reset(reset),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .vde_in(vde_in),
    .x_in(x_in), .y_in(y_in),
    .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof), .s_ready(s_ready),
    .clear_err(clear_err),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .vde_out(vde_out),
    .rgb_out(rgb_out), .locked(locked), .underflow(underflow), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vde;
    logic [23:0] rgb;
    logic        lck;
    logic        uf;
    logic        mis;
    logic        rdy;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        exp_next;
  exp_t        exp_cur;
  bit          chk_en = 1'b0;

  logic [24:0] mq[$];
  int          mstate = M_SEEK;
  logic        m_uf = 1'b0;
  logic        m_mis = 1'b0;

  logic [24:0] src[$];
  int          rate = 100;
  bit          blank_mode = 1'b0;
  bit          rst_req = 1'b1;
  bit          clr_req = 1'b0;
  int          hx = 0;
  int          vy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("hsync_out", 32'(hsync_out), 32'(exp_cur.hs));
      check("vsync_out", 32'(vsync_out), 32'(exp_cur.vs));
      check("vde_out",   32'(vde_out),   32'(exp_cur.vde));
      check("rgb_out",   32'(rgb_out),   32'(exp_cur.rgb));
      check("locked",    32'(locked),    32'(exp_cur.lck));
      check("underflow", 32'(underflow), 32'(exp_cur.uf));
      check("misalign",  32'(misalign),  32'(exp_cur.mis));
      check("s_ready",   32'(s_ready),   32'(exp_cur.rdy));
    end
  end

  // Model of the feeder rules for the inputs currently driven; returns whether a push happens.
  task automatic model_step(output bit push);
    bit          full;
    bit          empty;
    bit          start;
    bit          hsof;
    logic [23:0] hd;
    logic [23:0] rgb;
    bit          pop;
    bit          ufs;
    bit          mss;
    push = 1'b0;
    if (reset) begin
      mq.delete();
      mstate = M_SEEK;
      m_uf = 1'b0;
      m_mis = 1'b0;
      exp_next.hs = 1'b1; exp_next.vs = 1'b1; exp_next.vde = 1'b0;
      exp_next.rgb = 24'h0; exp_next.lck = 1'b0; exp_next.uf = 1'b0;
      exp_next.mis = 1'b0; exp_next.rdy = 1'b1;
      return;
    end
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    push  = s_valid && !full;
    start = vde_in && x_in == 10'd0 && y_in == 10'd0;
    hsof  = empty ? 1'b0 : mq[0][24];
    hd    = empty ? 24'h0 : mq[0][23:0];
    rgb   = vde_in ? BLANK : 24'h0;
    pop = 1'b0; ufs = 1'b0; mss = 1'b0;
    if (mstate == M_SEEK) begin
      if (!empty && hsof) mstate = M_WAIT;
      else if (!empty) pop = 1'b1;
    end else if (mstate == M_WAIT) begin
      if (start && !empty && hsof) begin
        pop = 1'b1; rgb = hd; mstate = M_LOCKED;
      end
    end else if (vde_in) begin
      if (empty) begin
        ufs = 1'b1; mstate = M_SEEK;
      end else if (hsof && !start) begin
        mss = 1'b1; mstate = M_WAIT;
      end else if (start && !hsof) begin
        mss = 1'b1; mstate = M_SEEK;
      end else begin
        pop = 1'b1; rgb = hd;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({s_sof, s_data});
    m_uf  = ufs || (m_uf && !clear_err);
    m_mis = mss || (m_mis && !clear_err);
    exp_next.hs = hsync_in; exp_next.vs = vsync_in; exp_next.vde = vde_in;
    exp_next.rgb = rgb; exp_next.lck = (mstate == M_LOCKED);
    exp_next.uf = m_uf; exp_next.mis = m_mis; exp_next.rdy = (mq.size() < DEPTH);
  endtask

  // One clock: latch expectations, drive raster and stream, step the model.
  task automatic cycle();
    bit push;
    @(posedge clk);
    exp_cur = exp_next;
    #1;
    reset     = rst_req;
    clear_err = clr_req;
    vde_in    = !blank_mode && hx < H_ACT && vy < V_ACT;
    x_in      = 10'(hx);
    y_in      = 10'(vy);
    hsync_in  = !(hx >= 34 && hx < 38);
    vsync_in  = !(vy >= 9 && vy < 11);
    s_valid   = (src.size() > 0) && ($urandom_range(99) < rate);
    if (src.size() > 0) {s_sof, s_data} = src[0];
    else {s_sof, s_data} = 25'h0;
    model_step(push);
    if (push) void'(src.pop_front());
    hx++;
    if (hx == H_TOT) begin
      hx = 0;
      vy = (vy + 1) % V_TOT;
    end
  endtask

  task automatic add_frame(input int id, input int len);
    logic [7:0]  idb;
    logic [15:0] ib;
    idb = 8'(id);
    for (int i = 0; i < len; i++) begin
      ib = 16'(i);
      src.push_back({(i == 0) ? 1'b1 : 1'b0, idb, ib});
    end
  endtask

  task automatic run_until(input int x, input int y);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(vde_in && x_in == 10'(x) && y_in == 10'(y)) && n < 3000);
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL run_until timeout actual=%0d expected<3000", n);
    end
  endtask

  initial begin
    // Reset and reset-state outputs.
    rst_req = 1'b1;
    cycle();
    cycle();
    chk_en = 1'b1;
    rst_req = 1'b0;
    check("pin_rst_hsync",  32'(hsync_out), 32'd1);
    check("pin_rst_vsync",  32'(vsync_out), 32'd1);
    check("pin_rst_rgb",    32'(rgb_out),   32'd0);
    check("pin_rst_locked", 32'(locked),    32'd0);
    check("pin_rst_ready",  32'(s_ready),   32'd1);

    // Idle raster with no stream.
    repeat (600) cycle();
    check("pin_idle_locked", 32'(locked),  32'd0);
    check("pin_idle_ready",  32'(s_ready), 32'd1);

    // Five stray pixels ahead of frame 1, then frame 2 back to back.
    for (int i = 0; i < 5; i++) src.push_back({1'b0, 24'hEE0000 + 24'(i)});
    add_frame(1, 256);
    add_frame(2, 256);
    run_until(0, 0);
    cycle();
    check("pin_lock1",     32'(locked),  32'd1);
    check("pin_f1_px0",    32'(rgb_out), 32'h010000);
    cycle();
    check("pin_f1_px1",    32'(rgb_out), 32'h010001);
    run_until(5, 2);
    cycle();
    check("pin_f1_x5y2",   32'(rgb_out), 32'h010045);
    run_until(0, 0);
    cycle();
    check("pin_f2_px0",    32'(rgb_out),   32'h020000);
    check("pin_f2_locked", 32'(locked),    32'd1);
    check("pin_f2_uf",     32'(underflow), 32'd0);
    check("pin_f2_mis",    32'(misalign),  32'd0);

    // Stream stall mid-line while locked.
    add_frame(3, 256);
    add_frame(4, 256);
    run_until(0, 0);
    run_until(2, 3);
    rate = 0;
    repeat (24) cycle();
    rate = 100;
    check("pin_stall_uf",     32'(underflow), 32'd1);
    check("pin_stall_locked", 32'(locked),    32'd0);
    run_until(0, 0);
    cycle();
    check("pin_relock4",   32'(locked),  32'd1);
    check("pin_f4_px0",    32'(rgb_out), 32'h040000);

    // Short frame: SOF of frame 6 arrives early.
    add_frame(5, 100);
    add_frame(6, 256);
    add_frame(7, 256);
    run_until(0, 0);
    run_until(0, 0);
    cycle();
    check("pin_mis_set",   32'(misalign), 32'd1);
    check("pin_relock6",   32'(locked),   32'd1);
    check("pin_f6_px0",    32'(rgb_out),  32'h060000);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    cycle();
    check("pin_mis_clr",   32'(misalign),  32'd0);
    check("pin_uf_clr",    32'(underflow), 32'd0);

    // Fill with no active video, then reset mid-frame.
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    src.delete();
    blank_mode = 1'b1;
    add_frame(8, 20);
    repeat (30) cycle();
    check("pin_full_ready", 32'(s_ready), 32'd0);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    src.delete();
    cycle();
    check("pin_rst2_ready",  32'(s_ready), 32'd1);
    check("pin_rst2_locked", 32'(locked),  32'd0);

    // Randomised traffic: varying rates, odd-length frames, clears and resets.
    blank_mode = 1'b0;
    for (int f = 9; f < 22; f++) begin
      int r;
      r = $urandom_range(9);
      add_frame(f, (r == 0) ? 180 : ((r == 1) ? 300 : 256));
    end
    for (int c = 0; c < 6000; c++) begin
      if (c % 50 == 0) rate = $urandom_range(100, 80);
      clr_req = ($urandom_range(99) == 0);
      rst_req = ($urandom_range(1999) == 0);
      cycle();
    end
    clr_req = 1'b0;
    rst_req = 1'b0;
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
